// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, fetch state encoding and alignment helpers
package fetch_pkg;

    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] PC_INCR    = 64'd4;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~64'h3;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_t;

    // Clear the byte-offset bits so the PC always names a whole word
    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC select with redirect alignment flag
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] LAST_ADDR = 64'h05C
) (
    input  logic                reset,
    input  logic                redirect,
    input  logic                stall,
    input  fetch_state_t        state,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [PC_WIDTH-1:0] start_pc,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                align_err,
    output logic                pc_in_range
);

    // Priority: reset, then redirect, then stall (hold), then sequential advance.
    // PC holds once it runs past the program; the wrap on PC + 4 is intentional.
    always_comb begin
        next_pc     = pc;
        align_err   = 1'b0;
        pc_in_range = (pc <= LAST_ADDR);
        if (reset) begin
            next_pc = start_pc;
        end else if (redirect) begin
            next_pc   = word_align(redirect_pc);
            align_err = |redirect_pc[1:0];
        end else if (!stall && state == FETCH && pc_in_range) begin
            next_pc = pc + PC_INCR;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, ROM fetch and IF/ID stage register
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] LAST_ADDR = 64'h05C
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [PC_WIDTH-1:0]    StartPC,
    input  logic                   Stall,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    RedirectPC,
    output logic [PC_WIDTH-1:0]    FetchAddress,
    input  logic [INSTR_WIDTH-1:0] FetchData,
    output logic [INSTR_WIDTH-1:0] IFID_Instruction,
    output logic [PC_WIDTH-1:0]    IFID_PC,
    output logic                   IFID_Valid,
    output logic                   Done,
    output logic                   AlignErr
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                align_d;
    logic                pc_in_range;

    fetch_pc_next #(
        .LAST_ADDR (LAST_ADDR)
    ) u_pc_next (
        .reset       (Reset),
        .redirect    (Redirect),
        .stall       (Stall),
        .state       (state_q),
        .pc          (pc_q),
        .redirect_pc (RedirectPC),
        .start_pc    (StartPC),
        .next_pc     (pc_d),
        .align_err   (align_d),
        .pc_in_range (pc_in_range)
    );

    assign FetchAddress = pc_q;
    assign Done         = (state_q == DONE);

    // Next state: redirect always restarts fetch; running off the end halts
    always_comb begin
        state_d = state_q;
        if (Redirect) begin
            state_d = FETCH;
        end else if (!Stall && state_q == FETCH && !pc_in_range) begin
            state_d = DONE;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC register; the sub-module already folds in reset and priority
    always_ff @(posedge CLK) begin
        pc_q <= pc_d;
    end

    // IF/ID stage register: capture on a real fetch, flush on redirect, hold on stall
    always_ff @(posedge CLK) begin
        if (Reset) begin
            IFID_Instruction <= '0;
            IFID_PC          <= '0;
            IFID_Valid       <= 1'b0;
        end else if (Redirect) begin
            IFID_Valid <= 1'b0;
        end else if (!Stall) begin
            if (state_q == FETCH && pc_in_range) begin
                IFID_Instruction <= FetchData;
                IFID_PC          <= pc_q;
                IFID_Valid       <= 1'b1;
            end else begin
                IFID_Valid <= 1'b0;
            end
        end
    end

    // Misaligned-redirect pulse, cleared on every other edge
    always_ff @(posedge CLK) begin
        if (Reset) begin
            AlignErr <= 1'b0;
        end else begin
            AlignErr <= align_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [63:0] LAST = 64'h05C;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] StartPC = '0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [63:0] RedirectPC = '0;
    logic [63:0] FetchAddress;
    logic [31:0] FetchData;
    logic [31:0] IFID_Instruction;
    logic [63:0] IFID_PC;
    logic        IFID_Valid;
    logic        Done;
    logic        AlignErr;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [0:23];

    typedef struct {
        logic [63:0] fa;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic        v;
        logic        d;
        logic        a;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [63:0] m_pc = '0;
    logic [31:0] m_ins = '0;
    logic [63:0] m_ipc = '0;
    logic        m_v = 1'b0;
    logic        m_d = 1'b0;
    logic        m_a = 1'b0;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(.LAST_ADDR(LAST)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .StartPC          (StartPC),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .FetchAddress     (FetchAddress),
        .FetchData        (FetchData),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_Valid       (IFID_Valid),
        .Done             (Done),
        .AlignErr         (AlignErr)
    );

    function automatic logic [31:0] rom_word(input logic [63:0] addr);
        logic [4:0] idx;
        if (addr > LAST) return 32'hDEAD_BEEF;
        idx = addr[6:2];
        return rom[idx];
    endfunction

    assign FetchData = rom_word(FetchAddress);

    initial begin
        rom[0]  = 32'hF84003E9; rom[1]  = 32'hF84083EA; rom[2]  = 32'hF84103EB;
        rom[3]  = 32'hF84183EC; rom[4]  = 32'hF84203ED; rom[5]  = 32'hAA0B014A;
        rom[6]  = 32'h8B0A018C; rom[7]  = 32'hCB0B01AD; rom[8]  = 32'h8B0901AD;
        rom[9]  = 32'hB400008E; rom[10] = 32'h1400000F; rom[11] = 32'hD2800010;
        rom[12] = 32'hAA1003F1; rom[13] = 32'hD282468A; rom[14] = 32'hD28ACF0A;
        rom[15] = 32'h8B0A0252; rom[16] = 32'hCB130273; rom[17] = 32'hB4FFFF94;
        rom[18] = 32'hF80003E9; rom[19] = 32'hF80083EA; rom[20] = 32'h8A0B0294;
        rom[21] = 32'hAA1503F6; rom[22] = 32'h17FFFFF5; rom[23] = 32'hF84203ED;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Apply one edge's worth of rules to the model, in priority order
    task automatic model_edge();
        if (Reset) begin
            m_pc = StartPC; m_ins = '0; m_ipc = '0; m_v = 0; m_d = 0; m_a = 0;
        end else if (Redirect) begin
            m_pc = {RedirectPC[63:2], 2'b00};
            m_v  = 0;
            m_d  = 0;
            m_a  = (RedirectPC % 4) != 0;
        end else if (Stall) begin
            m_a = 0;
        end else if (m_d) begin
            m_v = 0; m_a = 0;
        end else if (m_pc <= LAST) begin
            m_ins = rom_word(m_pc);
            m_ipc = m_pc;
            m_v   = 1;
            m_pc  = m_pc + 64'd4;
            m_a   = 0;
        end else begin
            m_d = 1; m_v = 0; m_a = 0;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rd,
                        input logic [63:0] rpc, input logic [63:0] spc);
        exp_t e;
        Reset = rst; Stall = st; Redirect = rd; RedirectPC = rpc; StartPC = spc;
        model_edge();
        e.fa = m_pc; e.ins = m_ins; e.ipc = m_ipc; e.v = m_v; e.d = m_d; e.a = m_a;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
    endtask

    // Monitor: every cycle the DUT presents its registered outputs; compare to queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("fetch_address", FetchAddress, e.fa);
                check("ifid_valid", {63'd0, IFID_Valid}, {63'd0, e.v});
                check("done", {63'd0, Done}, {63'd0, e.d});
                check("align_err", {63'd0, AlignErr}, {63'd0, e.a});
                if (e.v) begin
                    check("ifid_instruction", {32'd0, IFID_Instruction}, {32'd0, e.ins});
                    check("ifid_pc", IFID_PC, e.ipc);
                end
            end
        end
    end

    initial begin
        logic [63:0] rpc;
        int          sel;

        // Reset and sequential fetch from 0
        step(1, 0, 0, '0, 64'h0);
        step(1, 0, 0, '0, 64'h0);
        check("tp_reset_fa", FetchAddress, 64'h000);
        check("tp_reset_valid", {63'd0, IFID_Valid}, 64'd0);
        Reset = 0;
        run(1);
        check("tp_first_ins", {32'd0, IFID_Instruction}, 64'hF84003E9);
        check("tp_first_pc", IFID_PC, 64'h000);
        run(1);
        check("tp_second_ins", {32'd0, IFID_Instruction}, 64'hF84083EA);
        run(3);

        // Stall three cycles at 0x014
        check("tp_stall_fa_before", FetchAddress, 64'h014);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0);
        check("tp_stall_fa", FetchAddress, 64'h014);
        check("tp_stall_hold", {32'd0, IFID_Instruction}, 64'hF84203ED);
        run(1);
        check("tp_after_stall_ins", {32'd0, IFID_Instruction}, 64'hAA0B014A);
        check("tp_after_stall_pc", IFID_PC, 64'h014);

        // Redirect back to 0x020 from 0x02C
        run(5);
        check("tp_pc_2c", FetchAddress, 64'h02C);
        step(0, 0, 1, 64'h020, '0);
        check("tp_redir_valid", {63'd0, IFID_Valid}, 64'd0);
        check("tp_redir_fa", FetchAddress, 64'h020);
        run(1);
        check("tp_redir_ins", {32'd0, IFID_Instruction}, 64'h8B0901AD);

        // Redirect wins over stall
        step(0, 1, 1, 64'h034, '0);
        check("tp_rs_fa", FetchAddress, 64'h034);
        run(1);
        check("tp_rs_ins", {32'd0, IFID_Instruction}, 64'hD282468A);

        // Run off the end of the program
        run(10);
        check("tp_last_ins", {32'd0, IFID_Instruction}, 64'hF84203ED);
        check("tp_last_pc", IFID_PC, 64'h05C);
        run(1);
        check("tp_done", {63'd0, Done}, 64'd1);
        check("tp_done_fa", FetchAddress, 64'h060);
        run(2);
        step(0, 0, 1, 64'h038, '0);
        check("tp_undone", {63'd0, Done}, 64'd0);
        run(1);
        check("tp_undone_ins", {32'd0, IFID_Instruction}, 64'hD28ACF0A);

        // Misaligned redirect and reset during stall
        step(0, 0, 1, 64'h03B, '0);
        check("tp_align_fa", FetchAddress, 64'h038);
        check("tp_align_pulse", {63'd0, AlignErr}, 64'd1);
        run(1);
        check("tp_align_clear", {63'd0, AlignErr}, 64'd0);
        step(0, 1, 0, '0, '0);
        step(1, 1, 1, 64'h010, 64'h034);
        check("tp_rst_stall_fa", FetchAddress, 64'h034);
        check("tp_rst_stall_done", {63'd0, Done}, 64'd0);

        // Redirect past the end re-enters DONE one edge later
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, '0);
        run(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            rpc = '0;
            if ($urandom_range(0, 3) == 0) rpc = {$urandom(), $urandom()};
            else rpc = 64'($urandom_range(0, 'h70));
            if (sel < 3) step(1, $urandom_range(0, 1), $urandom_range(0, 1), rpc,
                              64'($urandom_range(0, 24)) << 2);
            else if (sel < 15) step(0, $urandom_range(0, 1), 1, rpc, '0);
            else if (sel < 35) step(0, 1, 0, rpc, '0);
            else step(0, 0, 0, rpc, '0);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
